// File: rtl/cop0_pkg.sv
// Shared CP0 definitions: register addresses, write masks, reset values and
// Status/Cause field positions, used by the register bank and the write filter.
package cop0_pkg;

    localparam logic [4:0] RD_BADVADDR = 5'd8;
    localparam logic [4:0] RD_COUNT    = 5'd9;
    localparam logic [4:0] RD_COMPARE  = 5'd11;
    localparam logic [4:0] RD_STATUS   = 5'd12;
    localparam logic [4:0] RD_CAUSE    = 5'd13;
    localparam logic [4:0] RD_EPC      = 5'd14;
    localparam logic [4:0] RD_EBASE    = 5'd15;
    localparam logic [4:0] RD_LLADDR   = 5'd17;
    localparam logic [2:0] SEL_0       = 3'd0;
    localparam logic [2:0] SEL_EBASE   = 3'd1;

    localparam logic [31:0] WMASK_BADVADDR = 32'h0000_0000;
    localparam logic [31:0] WMASK_STATUS   = 32'h8040_FF17;
    localparam logic [31:0] WMASK_CAUSE    = 32'h0080_0300;
    localparam logic [31:0] WMASK_EPC      = 32'hFFFF_FFFF;
    localparam logic [31:0] WMASK_EBASE    = 32'h3FFF_F000;
    localparam logic [31:0] WMASK_LLADDR   = 32'h0000_0000;
    localparam logic [31:0] WMASK_COUNT    = 32'hFFFF_FFFF;
    localparam logic [31:0] WMASK_COMPARE  = 32'hFFFF_FFFF;

    localparam logic [31:0] RST_STATUS = 32'h0040_0004;
    localparam logic [31:0] RST_EBASE  = 32'h8000_0000;
    localparam logic [31:0] RST_ZERO   = 32'h0000_0000;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_ERL    = 2;
    localparam int ST_IM_LO  = 8;
    localparam int ST_IM_HI  = 15;
    localparam int ST_BEV    = 22;
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_IP_LO  = 8;
    localparam int CA_IP_HI  = 15;
    localparam int CA_HW_LO  = 10;
    localparam int CA_TI     = 30;
    localparam int CA_BD     = 31;

    localparam logic [31:0] VEC_BOOT   = 32'hBFC0_0380;
    localparam logic [11:0] VEC_OFFSET = 12'h180;

    typedef enum logic [3:0] {
        REG_NONE,
        REG_BADVADDR,
        REG_COUNT,
        REG_COMPARE,
        REG_STATUS,
        REG_CAUSE,
        REG_EPC,
        REG_EBASE,
        REG_LLADDR
    } cop0_reg_e;

    function automatic cop0_reg_e cop0_decode(input logic [4:0] rd, input logic [2:0] sel);
        cop0_reg_e r;
        r = REG_NONE;
        case ({rd, sel})
            {RD_BADVADDR, SEL_0}:     r = REG_BADVADDR;
            {RD_COUNT, SEL_0}:        r = REG_COUNT;
            {RD_COMPARE, SEL_0}:      r = REG_COMPARE;
            {RD_STATUS, SEL_0}:       r = REG_STATUS;
            {RD_CAUSE, SEL_0}:        r = REG_CAUSE;
            {RD_EPC, SEL_0}:          r = REG_EPC;
            {RD_EBASE, SEL_EBASE}:    r = REG_EBASE;
            {RD_LLADDR, SEL_0}:       r = REG_LLADDR;
            default:                  r = REG_NONE;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] wmerge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/cop0_timer.sv
// Count/Compare timer: prescaled Count, Compare register and the sticky timer interrupt TI.
module cop0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ti_q, ti_d;
    logic          hit_q, hit_d;
    logic          tick;
    logic [31:0]   count_inc;

    // A match is registered in hit_q and turned into TI one edge later, so a
    // Compare write landing on either of those edges suppresses the interrupt.
    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        count_inc = count_q + 32'd1;
        presc_d   = tick ? '0 : presc_q + PW'(1);
        count_d   = tick ? count_inc : count_q;
        hit_d     = tick && (count_inc == compare_q);
        compare_d = compare_q;
        ti_d      = ti_q | hit_q;
        if (count_we_i) begin
            count_d = wdata_i;
            presc_d = '0;
            hit_d   = 1'b0;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
            hit_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
            hit_q     <= hit_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cop0_regfile.sv
// CP0 register bank: masked mtc0 merge, exception/eret side effects, LL address,
// interrupt request and exception vector generation.
module cop0_regfile
    import cop0_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  rd,
    input  logic [2:0]  sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [5:0]  hw_int,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        exc_badvaddr_valid,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic        ll_valid,
    input  logic [31:0] ll_addr,
    output logic        int_req,
    output logic [31:0] exc_vector,
    output logic [31:0] epc,
    output logic [31:0] status,
    output logic [31:0] cause
);
    cop0_reg_e   reg_sel;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] ebase_q, ebase_d;
    logic [31:0] lladdr_q, lladdr_d;
    logic [31:0] count, compare;
    logic        ti;
    logic        count_we, compare_we;

    assign reg_sel    = cop0_decode(rd, sel);
    assign count_we   = we && (reg_sel == REG_COUNT);
    assign compare_we = we && (reg_sel == REG_COMPARE);

    cop0_timer #(
        .COUNT_DIV(COUNT_DIV)
    ) u_timer (
        .clk_i        (clk),
        .reset_i      (reset),
        .count_we_i   (count_we),
        .compare_we_i (compare_we),
        .wdata_i      (wdata),
        .count_o      (count),
        .compare_o    (compare),
        .ti_o         (ti)
    );

    // Actions are applied lowest priority first; each higher-priority action
    // overwrites only the fields it owns, so untouched fields keep the mtc0 merge.
    always_comb begin
        badvaddr_d = badvaddr_q;
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        ebase_d    = ebase_q;
        lladdr_d   = lladdr_q;
        if (we) begin
            case (reg_sel)
                REG_BADVADDR: badvaddr_d = wmerge(badvaddr_q, wdata, WMASK_BADVADDR);
                REG_STATUS:   status_d   = wmerge(status_q, wdata, WMASK_STATUS);
                REG_CAUSE:    cause_d    = wmerge(cause_q, wdata, WMASK_CAUSE);
                REG_EPC:      epc_d      = wmerge(epc_q, wdata, WMASK_EPC);
                REG_EBASE:    ebase_d    = wmerge(ebase_q, wdata, WMASK_EBASE);
                REG_LLADDR:   lladdr_d   = wmerge(lladdr_q, wdata, WMASK_LLADDR);
                default:      ;
            endcase
        end
        if (eret) begin
            if (status_q[ST_ERL]) status_d[ST_ERL] = 1'b0;
            else                  status_d[ST_EXL] = 1'b0;
        end
        if (exc_valid) begin
            if (!status_q[ST_EXL]) begin
                epc_d          = exc_pc;
                cause_d[CA_BD] = exc_bd;
            end
            cause_d[CA_EXC_HI:CA_EXC_LO] = exc_code;
            status_d[ST_EXL]             = 1'b1;
            if (exc_badvaddr_valid) badvaddr_d = exc_badvaddr;
        end
        cause_d[CA_IP_HI:CA_HW_LO] = hw_int | {ti, 5'b0};
        if (ll_valid) lladdr_d = ll_addr >> 4;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            badvaddr_q <= RST_ZERO;
            status_q   <= RST_STATUS;
            cause_q    <= RST_ZERO;
            epc_q      <= RST_ZERO;
            ebase_q    <= RST_EBASE;
            lladdr_q   <= RST_ZERO;
        end else begin
            badvaddr_q <= badvaddr_d;
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            ebase_q    <= ebase_d;
            lladdr_q   <= lladdr_d;
        end
    end

    // TI lives in the timer; cause_q bit 30 is never written and stays zero.
    assign cause      = ti ? (cause_q | (32'h1 << CA_TI)) : cause_q;
    assign status     = status_q;
    assign epc        = epc_q;
    assign exc_vector = status_q[ST_BEV] ? VEC_BOOT : {ebase_q[31:12], VEC_OFFSET};
    assign int_req    = status_q[ST_IE] && !status_q[ST_EXL] && !status_q[ST_ERL] &&
                        (|(cause_q[CA_IP_HI:CA_IP_LO] & status_q[ST_IM_HI:ST_IM_LO]));

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count;
            REG_COMPARE:  rdata = compare;
            REG_STATUS:   rdata = status_q;
            REG_CAUSE:    rdata = cause;
            REG_EPC:      rdata = epc_q;
            REG_EBASE:    rdata = ebase_q;
            REG_LLADDR:   rdata = lladdr_q;
            default:      rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cop0_regfile.sv
// Directed plus randomized bench for cop0_regfile against a field-level reference model.
module tb_cop0_regfile;
  localparam int DIV = 2;
  localparam int R_BADV = 0, R_COUNT = 1, R_COMPARE = 2, R_STATUS = 3;
  localparam int R_CAUSE = 4, R_EPC = 5, R_EBASE = 6, R_LL = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b0, we = 1'b0;
  logic [4:0]  rd = '0;
  logic [2:0]  sel = '0;
  logic [31:0] wdata = '0, rdata;
  logic [5:0]  hw_int = '0;
  logic        exc_valid = 1'b0, exc_bd = 1'b0, exc_badvaddr_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_pc = '0, exc_badvaddr = '0;
  logic        eret = 1'b0, ll_valid = 1'b0;
  logic [31:0] ll_addr = '0;
  logic        int_req;
  logic [31:0] exc_vector, epc, status, cause;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] m_reg [8];
  logic [31:0] n_reg [8];
  int          m_presc, n_presc;
  bit          m_ti, n_ti, m_pend, n_pend;

  always #10 clk = ~clk;

  cop0_regfile #(.COUNT_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .we(we), .rd(rd), .sel(sel), .wdata(wdata), .rdata(rdata),
    .hw_int(hw_int), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .exc_badvaddr_valid(exc_badvaddr_valid), .exc_badvaddr(exc_badvaddr),
    .eret(eret), .ll_valid(ll_valid), .ll_addr(ll_addr), .int_req(int_req),
    .exc_vector(exc_vector), .epc(epc), .status(status), .cause(cause)
  );

  function automatic logic [4:0] reg_rd(input int i);
    case (i)
      R_BADV: return 5'd8;     R_COUNT: return 5'd9;   R_COMPARE: return 5'd11;
      R_STATUS: return 5'd12;  R_CAUSE: return 5'd13;  R_EPC: return 5'd14;
      R_EBASE: return 5'd15;   default: return 5'd17;
    endcase
  endfunction

  function automatic logic [2:0] reg_sel(input int i);
    return (i == R_EBASE) ? 3'd1 : 3'd0;
  endfunction

  function automatic logic [31:0] wmask(input int i);
    case (i)
      R_STATUS: return 32'h8040_FF17;
      R_CAUSE:  return 32'h0080_0300;
      R_EBASE:  return 32'h3FFF_F000;
      R_BADV, R_LL: return 32'h0;
      default:  return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] rstval(input int i);
    if (i == R_STATUS) return 32'h0040_0004;
    if (i == R_EBASE) return 32'h8000_0000;
    return 32'h0;
  endfunction

  function automatic int lookup(input logic [4:0] r, input logic [2:0] s);
    for (int i = 0; i < 8; i++) if (reg_rd(i) == r && reg_sel(i) == s) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_cause_full();
    return m_reg[R_CAUSE] | (m_ti ? 32'h4000_0000 : 32'h0);
  endfunction

  function automatic logic [31:0] m_read(input int i);
    if (i < 0) return 32'h0;
    if (i == R_CAUSE) return m_cause_full();
    return m_reg[i];
  endfunction

  function automatic logic m_int_req();
    logic [31:0] st, ca;
    st = m_reg[R_STATUS];
    ca = m_cause_full();
    return st[0] && !st[1] && !st[2] && ((ca[15:8] & st[15:8]) != 8'h0);
  endfunction

  function automatic logic [31:0] m_vector();
    logic [31:0] eb;
    eb = m_reg[R_EBASE];
    return m_reg[R_STATUS][22] ? 32'hBFC0_0380 : {eb[31:12], 12'h180};
  endfunction

  // Next architectural state from the current inputs; touched[] records fields
  // already claimed by a higher-priority action so lower ones leave them alone.
  task automatic model_step();
    logic [31:0] touched [8];
    logic [31:0] keep;
    int widx, b;
    if (reset) begin
      for (int i = 0; i < 8; i++) n_reg[i] = rstval(i);
      n_presc = 0; n_ti = 0; n_pend = 0;
      return;
    end
    for (int i = 0; i < 8; i++) begin n_reg[i] = m_reg[i]; touched[i] = '0; end
    if (exc_valid) begin
      if (!m_reg[R_STATUS][1]) begin
        n_reg[R_EPC] = exc_pc;        touched[R_EPC] = '1;
        n_reg[R_CAUSE][31] = exc_bd;  touched[R_CAUSE][31] = 1'b1;
      end
      n_reg[R_CAUSE][6:2] = exc_code; touched[R_CAUSE][6:2] = 5'h1F;
      n_reg[R_STATUS][1] = 1'b1;      touched[R_STATUS][1] = 1'b1;
      if (exc_badvaddr_valid) begin n_reg[R_BADV] = exc_badvaddr; touched[R_BADV] = '1; end
    end
    if (eret) begin
      b = m_reg[R_STATUS][2] ? 2 : 1;
      if (!touched[R_STATUS][b]) begin n_reg[R_STATUS][b] = 1'b0; touched[R_STATUS][b] = 1'b1; end
    end
    widx = lookup(rd, sel);
    if (we && widx >= 0) begin
      keep = touched[widx] | ~wmask(widx);
      n_reg[widx] = (n_reg[widx] & keep) | (wdata & ~keep);
    end
    n_ti = m_ti || m_pend;
    n_pend = 0;
    if (we && widx == R_COUNT) n_presc = 0;
    else if (m_presc == DIV - 1) begin
      n_presc = 0;
      n_reg[R_COUNT] = m_reg[R_COUNT] + 32'd1;
      n_pend = (n_reg[R_COUNT] == m_reg[R_COMPARE]);
    end else n_presc = m_presc + 1;
    if (we && widx == R_COMPARE) begin n_ti = 0; n_pend = 0; end
    n_reg[R_CAUSE][15:10] = hw_int | {m_ti, 5'b0};
    if (ll_valid) n_reg[R_LL] = ll_addr >> 4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_status"}, status, m_reg[R_STATUS]);
    chk({tag, "_cause"}, cause, m_cause_full());
    chk({tag, "_epc"}, epc, m_reg[R_EPC]);
    chk({tag, "_vector"}, exc_vector, m_vector());
    chk({tag, "_int_req"}, {31'b0, int_req}, {31'b0, m_int_req()});
    chk({tag, "_rdata"}, rdata, m_read(lookup(rd, sel)));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) m_reg[i] = n_reg[i];
    m_presc = n_presc; m_ti = n_ti; m_pend = n_pend;
    reset = 0; we = 0; exc_valid = 0; exc_badvaddr_valid = 0; eret = 0; ll_valid = 0;
    check_out(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle("idle");
  endtask

  task automatic mtc0(input int r, input logic [31:0] d);
    we = 1; rd = reg_rd(r); sel = reg_sel(r); wdata = d;
    cycle("mtc0");
  endtask

  task automatic rd_chk(input string tag, input int r, input logic [31:0] exp);
    rd = reg_rd(r); sel = reg_sel(r);
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd = reg_rd(i); sel = reg_sel(i);
      #1;
      chk($sformatf("%s_reg%0d", tag, i), rdata, m_read(i));
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_presc = 0; m_ti = 0; m_pend = 0;

    // Reset, then a merged Status write.
    reset = 1;
    cycle("reset");
    chk("rst_status", status, 32'h0040_0004);
    chk("rst_vector", exc_vector, 32'hBFC0_0380);
    chk("rst_int_req", {31'b0, int_req}, 32'h0);
    check_regs("rst");
    mtc0(R_STATUS, 32'hFFFF_FFFF);
    chk("status_merge", status, 32'h8040_FF17);

    // Timer: Count 3 -> 5 over four cycles, TI one later, int_req one after that.
    mtc0(R_COMPARE, 32'd5);
    mtc0(R_COUNT, 32'd3);
    mtc0(R_STATUS, 32'h0000_8001);
    idle(3);
    rd_chk("count_eq_5", R_COUNT, 32'd5);
    chk("ti_not_yet", {31'b0, cause[30]}, 32'h0);
    idle(1);
    chk("ti_set", {31'b0, cause[30]}, 32'h1);
    chk("int_req_lag", {31'b0, int_req}, 32'h0);
    idle(1);
    chk("int_req_ti", {31'b0, int_req}, 32'h1);
    mtc0(R_COMPARE, 32'h0000_1000);
    chk("ti_cleared", {31'b0, cause[30]}, 32'h0);

    // Exceptions with EXL clear and then set.
    exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h8000_0100; exc_bd = 1;
    cycle("exc1");
    chk("exc1_epc", epc, 32'h8000_0100);
    chk("exc1_bd", {31'b0, cause[31]}, 32'h1);
    chk("exc1_code", {27'b0, cause[6:2]}, 32'd8);
    chk("exc1_exl", {31'b0, status[1]}, 32'h1);
    exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h8000_0200; exc_bd = 0;
    cycle("exc2");
    chk("exc2_epc_kept", epc, 32'h8000_0100);
    chk("exc2_bd_kept", {31'b0, cause[31]}, 32'h1);

    // Simultaneous commits.
    exc_valid = 1; eret = 1; exc_pc = 32'h8000_0204;
    cycle("exc_eret");
    chk("exc_eret_exl", {31'b0, status[1]}, 32'h1);
    eret = 1;
    cycle("eret");
    chk("eret_exl", {31'b0, status[1]}, 32'h0);
    exc_valid = 1; exc_pc = 32'h8000_0300; we = 1; rd = reg_rd(R_EPC); sel = reg_sel(R_EPC);
    wdata = 32'h0000_1234;
    cycle("exc_mtc0");
    chk("exc_mtc0_epc", epc, 32'h8000_0300);
    mtc0(R_COMPARE, 32'd12);
    mtc0(R_COUNT, 32'd10);
    idle(3);
    mtc0(R_COMPARE, 32'd12);
    chk("cmp_race_ti0", {31'b0, cause[30]}, 32'h0);
    idle(1);
    chk("cmp_race_ti1", {31'b0, cause[30]}, 32'h0);
    rd_chk("cmp_race_count", R_COUNT, 32'd12);

    // Vector, BadVAddr, LLAddr, hw_int latency.
    mtc0(R_STATUS, 32'h0040_8000);
    chk("vec_bev", exc_vector, 32'hBFC0_0380);
    mtc0(R_EBASE, 32'h0000_1000);
    mtc0(R_STATUS, 32'h0000_8000);
    chk("vec_ebase", exc_vector, 32'h8000_1180);
    exc_valid = 1; exc_badvaddr_valid = 1; exc_badvaddr = 32'hDEAD_BEEF; exc_pc = 32'h8000_0400;
    cycle("badv");
    rd_chk("badvaddr", R_BADV, 32'hDEAD_BEEF);
    ll_valid = 1; ll_addr = 32'h0000_1230;
    cycle("ll");
    rd_chk("lladdr", R_LL, 32'h0000_0123);
    hw_int = 6'h01; we = 1; rd = reg_rd(R_STATUS); sel = 3'd0; wdata = 32'h0000_0401;
    cycle("hwint");
    chk("hwint_req", {31'b0, int_req}, 32'h1);
    hw_int = 6'h00;
    cycle("hwint_off");
    chk("hwint_drop", {31'b0, int_req}, 32'h0);

    // Count wrap and reset colliding with an exception.
    mtc0(R_COUNT, 32'hFFFF_FFFF);
    idle(2);
    rd_chk("count_wrap", R_COUNT, 32'h0);
    reset = 1; exc_valid = 1; exc_pc = 32'h1234_5678;
    cycle("rst_exc");
    chk("rst_exc_status", status, 32'h0040_0004);
    chk("rst_exc_epc", epc, 32'h0);
    chk("rst_exc_cause", cause, 32'h0);
    rd_chk("rst_exc_ebase", R_EBASE, 32'h8000_0000);
    check_regs("rst_exc");

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        int r;
        r = $urandom_range(0, 9);
        we = 1;
        wdata = $urandom;
        if (r < 8) begin rd = reg_rd(r); sel = reg_sel(r); end
        else begin rd = 5'($urandom_range(0, 31)); sel = 3'($urandom_range(2, 7)); end
        if (r == R_COUNT) wdata = m_reg[R_COMPARE] - 32'($urandom_range(0, 6));
      end
      exc_valid = ($urandom_range(0, 15) == 0);
      exc_code = 5'($urandom); exc_pc = $urandom; exc_bd = 1'($urandom);
      exc_badvaddr_valid = 1'($urandom); exc_badvaddr = $urandom;
      eret = ($urandom_range(0, 9) == 0);
      ll_valid = ($urandom_range(0, 9) == 0); ll_addr = $urandom;
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      cycle("rand");
      rd = reg_rd($urandom_range(0, 7)); sel = 3'($urandom_range(0, 1));
      #1;
      chk("rand_read", rdata, m_read(lookup(rd, sel)));
    end
    check_regs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
